// File: rtl/bfxp_issue.sv
// bfxp_issue: issue buffer in front of the bit-field extract/place stage.
// It decodes the control word and rejects operations whose source or
// destination field would run past bit 31. Legal operations are queued in an
// in-order circular FIFO. Rejected operations are counted with a saturating
// counter and also set a sticky flag.
module bfxp_issue #(
   parameter int DEPTH = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [31:0] in_ctrl,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rs1,
   output logic [31:0] out_rs2,
   output logic [4:0]  out_start,
   output logic [4:0]  out_len,
   output logic [4:0]  out_dest,
   output logic [7:0]  err_count,
   output logic        err_flag
);

   localparam int             PW       = (DEPTH > 2) ? 2 : 1;
   localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
   localparam logic [2:0]     OCC_FULL = 3'(DEPTH);

   // Entry layout: {rs1[78:47], rs2[46:15], start[14:10], len[9:5], dest[4:0]}
   logic [78:0]   ent_q [DEPTH];
   logic [78:0]   ent_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          err_flag_q, err_flag_d;

   logic [4:0]    len_s, start_s, dest_s;
   logic          merge_s, legal_s, accept_s, push_s, reject_s, pop_s;
   logic [31:0]   rs2_sel_s;
   logic [78:0]   head_s;
   logic          unused_ctrl_s;

   // A field fits when base+len does not pass 32; 6-bit sum cannot overflow.
   function automatic logic fits32(input logic [4:0] base, input logic [4:0] len);
      logic [5:0] sum;
      sum = {1'b0, base} + {1'b0, len};
      return (sum <= 6'd32);
   endfunction

   // Circular pointer advance, wrapping from DEPTH-1 back to 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == PTR_LAST) begin
         n = '0;
      end else begin
         n = p + PW'(1);
      end
      return n;
   endfunction

   // Handshake flags come only from registered occupancy, never from out_ready.
   assign in_ready  = (cnt_q != OCC_FULL);
   assign out_valid = (cnt_q != 3'd0);

   assign head_s    = ent_q[rd_ptr_q];
   assign out_rs1   = head_s[78:47];
   assign out_rs2   = head_s[46:15];
   assign out_start = head_s[14:10];
   assign out_len   = head_s[9:5];
   assign out_dest  = head_s[4:0];
   assign err_count = err_cnt_q;
   assign err_flag  = err_flag_q;

   assign unused_ctrl_s = ^{in_ctrl[31:25], in_ctrl[23:21], in_ctrl[15:13], in_ctrl[7:5]};

   // Decode the incoming control word and classify this cycle's handshakes.
   always_comb begin
      len_s     = in_ctrl[4:0];
      start_s   = in_ctrl[12:8];
      dest_s    = in_ctrl[20:16];
      merge_s   = in_ctrl[24];
      legal_s   = fits32(start_s, len_s) && fits32(dest_s, len_s);
      accept_s  = in_valid & in_ready;
      push_s    = accept_s & legal_s;
      reject_s  = accept_s & ~legal_s;
      pop_s     = out_valid & out_ready;
      if (merge_s) begin
         rs2_sel_s = in_rs2;
      end else begin
         rs2_sel_s = 32'h0000_0000;
      end
   end

   // Next-state for pointers, occupancy, error tracking and entry storage.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
      end

      if (push_s) begin
         wr_ptr_d        = ptr_inc(wr_ptr_q);
         ent_d[wr_ptr_q] = {in_rs1, rs2_sel_s, start_s, len_s, dest_s};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase

      if (reject_s) begin
         err_flag_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else begin
         err_flag_d = err_flag_q;
         err_cnt_d  = err_cnt_q;
      end
   end

   // Validity and error state; cleared by the synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= 3'd0;
         err_cnt_q  <= 8'd0;
         err_flag_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
      end
   end

   // Entry storage carries no reset; only the validity state above is cleared.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_q[i] <= ent_d[i];
      end
   end

endmodule

// File: tb/tb_bfxp_issue.sv
// Scoreboard bench for bfxp_issue (DEPTH = 2). Stimulus pushes the expected
// outputs into a queue. A negedge monitor pops and compares the queue on
// every output handshake.
module tb_bfxp_issue;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  start;
      logic [4:0]  len;
      logic [4:0]  dest;
   } exp_t;

   logic        clock;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [31:0] in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic [4:0]  out_start;
   logic [4:0]  out_len;
   logic [4:0]  out_dest;
   logic [7:0]  err_count;
   logic        err_flag;

   exp_t sb[$];
   int   errors;
   int   checks;
   int   cyc;
   int   npops;
   int   pop_cyc [1024];
   logic ov_at_acc;

   bfxp_issue #(.DEPTH(2)) dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_start(out_start), .out_len(out_len), .out_dest(out_dest),
      .err_count(err_count), .err_flag(err_flag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle counter used to measure spacing between output handshakes.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ignored control bits carry junk so that decoding must mask them.
   function automatic logic [31:0] mk_ctrl(input logic [4:0] st, input logic [4:0] ln,
                                           input logic [4:0] ds, input logic mg);
      return {7'b1010101, mg, 3'b101, ds, 3'b011, st, 3'b110, ln};
   endfunction

   // Monitor: compare the head against the scoreboard on every output handshake.
   always @(negedge clock) begin
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", out_rs1, 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_rs1",   out_rs1,          e.rs1);
            chk("out_rs2",   out_rs2,          e.rs2);
            chk("out_start", {27'd0, out_start}, {27'd0, e.start});
            chk("out_len",   {27'd0, out_len},   {27'd0, e.len});
            chk("out_dest",  {27'd0, out_dest},  {27'd0, e.dest});
         end
         if (npops < 1024) pop_cyc[npops] = cyc;
         npops++;
      end
   end

   // Present one op and hold it until accepted (bounded); in_valid is left high.
   task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] st, input logic [4:0] ln, input logic [4:0] ds,
                        input logic mg, input logic legal);
      bit   done;
      exp_t e;
      in_valid = 1'b1;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_ctrl  = mk_ctrl(st, ln, ds, mg);
      done     = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clock);
         if (in_ready === 1'b1) begin
            done      = 1'b1;
            ov_at_acc = out_valid;
            if (legal) begin
               e.rs1   = rs1;
               e.rs2   = mg ? rs2 : 32'h0000_0000;
               e.start = st;
               e.len   = ln;
               e.dest  = ds;
               sb.push_back(e);
            end
         end
         @(posedge clock);
         #1;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge clock);
         #1;
         k++;
      end
      chk("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      errors = 0; checks = 0; cyc = 0; npops = 0; ov_at_acc = 1'b0;
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rs1 = 32'd0; in_rs2 = 32'd0; in_ctrl = 32'd0;
      repeat (3) @(posedge clock);
      #1 resetn = 1'b1;

      // Reset state
      @(negedge clock);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      chk("rst_err_flag",  {31'd0, err_flag},  32'd0);
      @(posedge clock); #1;

      // Single op, one-cycle latency, then empty
      out_ready = 1'b1;
      issue(32'hDEADBEEF, 32'h0000_00FF, 5'd8, 5'd8, 5'd16, 1'b1, 1'b1);
      chk("no_bypass", {31'd0, ov_at_acc}, 32'd0);
      idle();
      @(negedge clock);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("empty_after", {31'd0, out_valid}, 32'd0);
      @(posedge clock); #1;

      // merge_en = 0 zeroes rs2
      issue(32'h1234_5678, 32'hFFFF_FFFF, 5'd4, 5'd16, 5'd0, 1'b0, 1'b1);
      idle();
      wait_empty();

      // Illegal ops and the legal boundaries
      issue(32'hAAAA_0001, 32'h1, 5'd28, 5'd8, 5'd0, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      chk("ill1_err_count", {24'd0, err_count}, 32'd1);
      chk("ill1_err_flag",  {31'd0, err_flag},  32'd1);
      chk("ill1_no_out",    {31'd0, out_valid}, 32'd0);
      @(posedge clock); #1;
      issue(32'hAAAA_0002, 32'h2, 5'd0, 5'd2, 5'd31, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      chk("ill2_err_count", {24'd0, err_count}, 32'd2);
      @(posedge clock); #1;
      issue(32'hBBBB_0001, 32'h3, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1);
      issue(32'hBBBB_0002, 32'h4, 5'd24, 5'd8, 5'd24, 1'b1, 1'b1);
      issue(32'hBBBB_0003, 32'h5, 5'd31, 5'd1, 5'd0, 1'b0, 1'b1);
      issue(32'hAAAA_0003, 32'h6, 5'd17, 5'd16, 5'd0, 1'b1, 1'b0);
      issue(32'hAAAA_0004, 32'h7, 5'd0, 5'd17, 5'd16, 1'b1, 1'b0);
      issue(32'hAAAA_0005, 32'h8, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0);
      idle();
      wait_empty();
      @(negedge clock);
      chk("ill5_err_count", {24'd0, err_count}, 32'd5);
      @(posedge clock); #1;

      // Illegal op accepted in the same cycle as a pop
      out_ready = 1'b0;
      issue(32'hCCCC_0001, 32'h9, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      idle();
      out_ready = 1'b1;
      issue(32'hAAAA_0006, 32'hA, 5'd20, 5'd20, 5'd0, 1'b1, 1'b0);
      idle();
      @(negedge clock);
      chk("popill_out_valid", {31'd0, out_valid}, 32'd0);
      chk("popill_err_count", {24'd0, err_count}, 32'd6);
      chk("popill_in_ready",  {31'd0, in_ready},  32'd1);
      chk("popill_sb_empty",  sb.size(), 32'd0);
      @(posedge clock); #1;

      // Fill with back-pressure, blocked third op, in-order drain
      out_ready = 1'b0;
      issue(32'hDDDD_0001, 32'h11, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1);
      issue(32'hDDDD_0002, 32'h22, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
      in_rs1 = 32'hDDDD_0003; in_ctrl = mk_ctrl(5'd1, 5'd1, 5'd1, 1'b1);
      @(negedge clock);
      chk("full_in_ready",  {31'd0, in_ready},  32'd0);
      chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      chk("full_head_hold", out_rs1, 32'hDDDD_0001);
      @(posedge clock); #1;
      @(negedge clock);
      chk("full_in_ready2", {31'd0, in_ready}, 32'd0);
      chk("full_head_hold2", out_rs1, 32'hDDDD_0001);
      @(posedge clock); #1;
      idle();
      out_ready = 1'b1;
      @(negedge clock);
      chk("full_in_ready3", {31'd0, in_ready}, 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clock); #1;
      wait_empty();

      // Streaming at full throughput with pointer wrap
      p0 = npops;
      for (int i = 0; i < 10; i++) begin
         issue(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 5'(i), 5'd4, 5'(i + 1),
               1'(i % 2), 1'b1);
      end
      idle();
      wait_empty();
      chk("stream_count", npops - p0, 32'd10);
      chk("stream_no_bubble", pop_cyc[p0 + 9] - pop_cyc[p0], 32'd9);

      // Reset with two entries buffered
      out_ready = 1'b0;
      issue(32'hEEEE_0001, 32'h1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1);
      issue(32'hEEEE_0002, 32'h2, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1);
      resetn = 1'b0;
      in_rs1 = 32'hEEEE_0003;
      @(posedge clock); #1;
      resetn = 1'b1;
      idle();
      sb.delete();
      @(negedge clock);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      chk("mid_rst_err_flag",  {31'd0, err_flag},  32'd0);
      @(posedge clock); #1;

      // in_valid during reset on an empty buffer is not accepted
      resetn   = 1'b0;
      in_valid = 1'b1;
      in_ctrl  = mk_ctrl(5'd0, 5'd1, 5'd0, 1'b1);
      @(posedge clock); #1;
      resetn = 1'b1;
      idle();
      @(negedge clock);
      chk("rst_no_accept", {31'd0, out_valid}, 32'd0);
      @(posedge clock); #1;

      // Saturating error counter
      out_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         issue(32'(i), 32'd0, 5'd30, 5'd8, 5'd0, 1'b1, 1'b0);
      end
      idle();
      @(negedge clock);
      chk("sat_255", {24'd0, err_count}, 32'd255);
      @(posedge clock); #1;
      for (int i = 0; i < 45; i++) begin
         issue(32'(i), 32'd0, 5'd0, 5'd8, 5'd30, 1'b1, 1'b0);
      end
      idle();
      @(negedge clock);
      chk("sat_hold", {24'd0, err_count}, 32'd255);
      chk("sat_flag", {31'd0, err_flag},  32'd1);
      chk("sat_no_out", {31'd0, out_valid}, 32'd0);
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bfxp_issue.md
BFXP_ISSUE -- requirements
Module: bfxp_issue

Interface
REQ-001 Parameter DEPTH, default 2, number of issue-buffer entries; legal values 2 and 4 only.
REQ-002 clock  input  1  single clock; all state changes on posedge.
REQ-003 resetn  input  1  synchronous, active-low reset; sampled on posedge clock.
REQ-004 in_valid  input  1  upstream operation present.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 in_rs1  input  32  source word to extract from.
REQ-007 in_rs2  input  32  merge base word.
REQ-008 in_ctrl  input  32  control word: [4:0] len, [12:8] start, [20:16] dest, [24] merge_en; other bits ignored.
REQ-009 out_valid  output  1  decoded operation available to the bit-field extract/place stage.
REQ-010 out_ready  input  1  extract/place stage consumes the operation this cycle.
REQ-011 out_rs1, out_rs2  output  32 each  operands for the extract/place stage.
REQ-012 out_start, out_len, out_dest  output  5 each  field controls for the extract/place stage.
REQ-013 err_count  output  8  count of rejected (illegal) operations; saturating.
REQ-014 err_flag  output  1  sticky; set by any rejected operation.

Function
REQ-015 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-016 Legality, evaluated at accept in 6-bit unsigned arithmetic: start+len <= 32 and dest+len <= 32; len = 0 is legal.
REQ-017 Legal accepted op: push one entry {rs1, merge_en ? rs2 : 32'h0, start, len, dest} into the FIFO.
REQ-018 Illegal accepted op: no push; err_count += 1, holding at 8'hFF; err_flag <= 1.
REQ-019 FIFO is in-order, DEPTH entries, circular read/write pointers that wrap from DEPTH-1 to 0; occupancy counter 0..DEPTH.
REQ-020 in_ready = (occupancy < DEPTH), registered-state-derived only; no combinational path from out_ready to in_ready.
REQ-021 out_valid = (occupancy != 0); out_* always driven from the head entry; out_* are don't-care while out_valid = 0.
REQ-022 Latency: a legal op accepted in cycle N is visible at out_* with out_valid = 1 in cycle N+1 at the earliest; no same-cycle bypass.
REQ-023 Simultaneous legal push and pop: occupancy unchanged; both pointers advance.
REQ-024 Full: in_ready = 0, so no push occurs even if a pop happens in the same cycle.
REQ-025 Empty: pop is impossible (out_valid = 0); out_ready is ignored.
REQ-026 Back-pressure: while out_valid = 1 and out_ready = 0, the head entry and all out_* stay stable.
REQ-027 Illegal op accepted in the same cycle as a pop: occupancy decreases by 1 and err_count increments.
REQ-028 Rejected ops never reach out_* and do not reorder legal ops.

Reset
REQ-029 resetn = 0 at posedge: occupancy, pointers and err_count go to 0 and err_flag to 0, so out_valid = 0 and in_ready = 1 in the following cycle.
REQ-030 Reset mid-operation discards all buffered entries, and in_valid asserted in the reset cycle is not accepted.
REQ-031 FIFO data storage is not reset; only validity state is cleared.

Verification
REQ-032 Single op: rs1 = 32'hDEADBEEF, rs2 = 32'h0000_00FF, ctrl start = 8, len = 8, dest = 16, merge_en = 1, out_ready = 1 -> next cycle out_valid = 1 with the same rs1, rs2, start/len/dest; then empty.
REQ-033 merge_en = 0 with rs2 = 32'hFFFF_FFFF -> out_rs2 = 32'h0.
REQ-034 Illegal ops: start = 28, len = 8 -> no output, err_count = 1, err_flag = 1; dest = 31, len = 2 -> err_count = 2; start = 0, len = 0, dest = 31 -> legal and forwarded.
REQ-035 Fill with out_ready = 0 and DEPTH = 2: two legal pushes -> in_ready = 0 and a third in_valid is not accepted; then out_ready = 1 -> ops emerge in order, and in_ready returns 1 the cycle after the first pop.
REQ-036 Streaming at 100% throughput with in_valid = out_ready = 1 for 10 cycles -> 10 ops out in order with no bubbles after the first; pointer wrap is exercised.
REQ-037 Pulse resetn = 0 with 2 entries buffered -> out_valid = 0, in_ready = 1 and err_count = 0 next cycle; 300 illegal ops -> err_count saturates at 255.
